// File: rtl/inst_mem_if.sv
// Bus bundle between the instruction memory, the CPU fetch port and the
// byte-serial program loader. Signal suffixes are from the memory's side.
interface inst_mem_if #(
    parameter int unsigned DEPTH_LOG2 = 10
);
    // CPU fetch port
    logic                  rom_ce_i;
    logic [31:0]           rom_addr_i;
    logic [31:0]           rom_data_o;
    // Loader byte stream
    logic                  ld_valid_i;
    logic [7:0]            ld_data_i;
    logic                  ld_last_i;
    logic                  ld_ready_o;
    // Status
    logic                  cpu_rst_o;
    logic                  load_done_o;
    logic                  ld_err_o;
    logic [DEPTH_LOG2:0]   words_o;

    // Memory side
    modport slave (
        input  rom_ce_i, rom_addr_i, ld_valid_i, ld_data_i, ld_last_i,
        output rom_data_o, ld_ready_o, cpu_rst_o, load_done_o, ld_err_o, words_o
    );

    // CPU / loader side
    modport master (
        output rom_ce_i, rom_addr_i, ld_valid_i, ld_data_i, ld_last_i,
        input  rom_data_o, ld_ready_o, cpu_rst_o, load_done_o, ld_err_o, words_o
    );
endinterface

// File: rtl/inst_mem.sv
// Instruction memory with a byte-serial loader. Bytes are packed big-endian
// into 32-bit words during LOAD; once the last byte arrives the memory
// switches to RUN, releases the CPU from reset and serves fetches.
module inst_mem #(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    inst_mem_if.slave   bus
);
    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    typedef enum logic {StLoad, StRun} state_e;

    state_e                state_q;
    logic [1:0]            cnt_q;
    logic [DEPTH_LOG2:0]   words_q;
    logic [31:0]           asm_q;
    logic                  err_q;
    logic                  cpu_rst_q;

    logic [31:0]           mem_q [Depth];

    logic                  accept;
    logic                  full;
    logic                  commit;
    logic [31:0]           word_d;
    logic [DEPTH_LOG2-1:0] wptr;
    logic                  unused_addr_lsb;

    assign accept = bus.ld_valid_i && (state_q == StLoad);
    // words_q saturates at Depth; its MSB alone marks a full memory
    assign full   = words_q[DEPTH_LOG2];
    // Write pointer tracks the word count; never used once full, so no wrap
    assign wptr   = words_q[DEPTH_LOG2-1:0];
    assign commit = accept && !full && ((cnt_q == 2'd3) || bus.ld_last_i);

    // Merge the incoming byte into its lane; lower lanes of asm_q are still zero
    always_comb begin
        word_d = asm_q;
        unique case (cnt_q)
            2'd0: word_d[31:24] = bus.ld_data_i;
            2'd1: word_d[23:16] = bus.ld_data_i;
            2'd2: word_d[15:8]  = bus.ld_data_i;
            2'd3: word_d[7:0]   = bus.ld_data_i;
            default: ;
        endcase
    end

    // Loader FSM with registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StLoad;
            cnt_q     <= 2'd0;
            words_q   <= '0;
            asm_q     <= '0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else if (accept) begin
            if (full) begin
                err_q <= 1'b1;
            end else if (commit) begin
                words_q <= words_q + 1'b1;
                asm_q   <= '0;
                cnt_q   <= 2'd0;
            end else begin
                asm_q <= word_d;
                cnt_q <= cnt_q + 2'd1;
            end
            if (bus.ld_last_i) begin
                state_q   <= StRun;
                cpu_rst_q <= 1'b0;
            end
        end
    end

    // Word array write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (commit) begin
            mem_q[wptr] <= word_d;
        end
    end

    // Combinational fetch, gated by enable, RUN state and address range
    always_comb begin
        bus.rom_data_o = 32'h0;
        if (bus.rom_ce_i && (state_q == StRun) &&
            (bus.rom_addr_i[31:DEPTH_LOG2+2] == '0)) begin
            bus.rom_data_o = mem_q[bus.rom_addr_i[DEPTH_LOG2+1:2]];
        end
    end

    // Byte offset within a word is ignored on fetch
    assign unused_addr_lsb = ^bus.rom_addr_i[1:0];

    assign bus.ld_ready_o  = (state_q == StLoad);
    assign bus.load_done_o = (state_q == StRun);
    assign bus.cpu_rst_o   = cpu_rst_q;
    assign bus.ld_err_o    = err_q;
    assign bus.words_o     = words_q;
endmodule

// File: tb/tb_inst_mem.sv
// Directed bench for inst_mem: one instance at the default depth and a
// four-word instance for the overflow case.
module tb_inst_mem;
    logic clk;
    logic rst_a;
    logic rst_b;

    int checks;
    int failures;

    inst_mem_if #(.DEPTH_LOG2(10)) if_a ();
    inst_mem_if #(.DEPTH_LOG2(2))  if_b ();

    inst_mem #(.DEPTH_LOG2(10)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (if_a.slave)
    );

    inst_mem #(.DEPTH_LOG2(2)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (if_b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present one byte to instance a (sel=0) or b (sel=1) for one clock edge
    task automatic send(input bit sel, input logic [7:0] d, input logic last);
        if (!sel) begin
            if_a.ld_valid_i = 1'b1;
            if_a.ld_data_i  = d;
            if_a.ld_last_i  = last;
        end else begin
            if_b.ld_valid_i = 1'b1;
            if_b.ld_data_i  = d;
            if_b.ld_last_i  = last;
        end
        @(posedge clk);
        #1;
        if_a.ld_valid_i = 1'b0;
        if_a.ld_last_i  = 1'b0;
        if_b.ld_valid_i = 1'b0;
        if_b.ld_last_i  = 1'b0;
    endtask

    task automatic read_a(input logic [31:0] addr, output logic [31:0] data);
        if_a.rom_ce_i   = 1'b1;
        if_a.rom_addr_i = addr;
        #1;
        data = if_a.rom_data_o;
    endtask

    task automatic read_b(input logic [31:0] addr, output logic [31:0] data);
        if_b.rom_ce_i   = 1'b1;
        if_b.rom_addr_i = addr;
        #1;
        data = if_b.rom_data_o;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        #1;
        check("rst cpu_rst", 64'(if_a.cpu_rst_o), 64'd1);
        check("rst load_done", 64'(if_a.load_done_o), 64'd0);
        check("rst ready", 64'(if_a.ld_ready_o), 64'd1);
        check("rst words", 64'(if_a.words_o), 64'd0);
        check("rst err", 64'(if_a.ld_err_o), 64'd0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
    endtask

    logic [7:0]  prog1 [8];
    logic [7:0]  prog2 [6];
    rd_vec_t     vecs  [6];
    logic [31:0] rd;

    initial begin
        checks   = 0;
        failures = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.rom_ce_i = 1'b0; if_a.rom_addr_i = '0;
        if_a.ld_valid_i = 1'b0; if_a.ld_data_i = '0; if_a.ld_last_i = 1'b0;
        if_b.rom_ce_i = 1'b0; if_b.rom_addr_i = '0;
        if_b.ld_valid_i = 1'b0; if_b.ld_data_i = '0; if_b.ld_last_i = 1'b0;

        prog1 = '{8'h34, 8'h02, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        prog2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        vecs[0] = '{ce: 1'b1, addr: 32'h0000_0000, exp: 32'h3402_0005};
        vecs[1] = '{ce: 1'b1, addr: 32'h0000_0004, exp: 32'h0000_0000};
        vecs[2] = '{ce: 1'b0, addr: 32'h0000_0000, exp: 32'h0000_0000};
        vecs[3] = '{ce: 1'b1, addr: 32'h0000_1000, exp: 32'h0000_0000};
        vecs[4] = '{ce: 1'b1, addr: 32'h0000_0003, exp: 32'h3402_0005};
        vecs[5] = '{ce: 1'b1, addr: 32'h8000_0000, exp: 32'h0000_0000};

        @(posedge clk);
        reset_a();

        // Fetch during LOAD is blocked
        read_a(32'h0, rd);
        check("load-state read", 64'(rd), 64'd0);

        // First program: two words, last on byte 8
        for (int i = 0; i < 8; i++) begin
            send(1'b0, prog1[i], i == 7);
            if (i == 6) check("cpu_rst before last", 64'(if_a.cpu_rst_o), 64'd1);
        end
        check("cpu_rst after last", 64'(if_a.cpu_rst_o), 64'd0);
        check("load_done after last", 64'(if_a.load_done_o), 64'd1);
        check("words prog1", 64'(if_a.words_o), 64'd2);
        check("err prog1", 64'(if_a.ld_err_o), 64'd0);
        check("ready in run", 64'(if_a.ld_ready_o), 64'd0);

        for (int i = 0; i < 6; i++) begin
            if_a.rom_ce_i   = vecs[i].ce;
            if_a.rom_addr_i = vecs[i].addr;
            #1;
            check($sformatf("read vec %0d", i), 64'(if_a.rom_data_o), 64'(vecs[i].exp));
        end

        // Bytes in RUN are ignored
        send(1'b0, 8'hFF, 1'b1);
        send(1'b0, 8'hEE, 1'b0);
        check("run bytes words", 64'(if_a.words_o), 64'd2);
        read_a(32'h0, rd);
        check("run bytes word0", 64'(rd), 64'h3402_0005);

        // Second program: partial final word
        reset_a();
        for (int i = 0; i < 6; i++) send(1'b0, prog2[i], i == 5);
        check("words prog2", 64'(if_a.words_o), 64'd2);
        read_a(32'h0, rd);
        check("prog2 word0", 64'(rd), 64'hAABB_CCDD);
        read_a(32'h4, rd);
        check("prog2 partial word1", 64'(rd), 64'h1122_0000);

        // Reset mid-load discards the partial word, reload from word 0
        reset_a();
        for (int i = 0; i < 6; i++) send(1'b0, 8'h50 + 8'(i), 1'b0);
        check("mid-load words", 64'(if_a.words_o), 64'd1);
        reset_a();
        send(1'b0, 8'h12, 1'b0);
        send(1'b0, 8'h34, 1'b0);
        send(1'b0, 8'h56, 1'b0);
        send(1'b0, 8'h78, 1'b1);
        check("reload words", 64'(if_a.words_o), 64'd1);
        read_a(32'h0, rd);
        check("reload word0", 64'(rd), 64'h1234_5678);
        read_a(32'h4, rd);
        check("word1 kept from prior load", 64'(rd), 64'h1122_0000);

        // Overflow on the four-word instance
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(1'b1, 8'(i), i == 19);
            if (i == 15) begin
                check("ovf words at 16", 64'(if_b.words_o), 64'd4);
                check("ovf err at 16", 64'(if_b.ld_err_o), 64'd0);
            end
            if (i == 16) begin
                check("ovf words at 17", 64'(if_b.words_o), 64'd4);
                check("ovf err at 17", 64'(if_b.ld_err_o), 64'd1);
                check("ovf ready at 17", 64'(if_b.ld_ready_o), 64'd1);
            end
        end
        check("ovf load_done", 64'(if_b.load_done_o), 64'd1);
        check("ovf err sticky", 64'(if_b.ld_err_o), 64'd1);
        read_b(32'h0, rd);
        check("ovf word0", 64'(rd), 64'h0001_0203);
        read_b(32'hC, rd);
        check("ovf word3", 64'(rd), 64'h0C0D_0E0F);
        read_b(32'h10, rd);
        check("ovf out of range", 64'(rd), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
